// File: rtl/decode_ctrl_if.sv
// Fetch-side and decode-side handshake bundle for decode_ctrl.
// slave is the controller's view; master is the fetch/decoder environment's view.
interface decode_ctrl_if #(
    parameter int unsigned ILEN = 32,
    parameter int unsigned XLEN = 32
);
    logic            f_valid;
    logic [ILEN-1:0] f_instr;
    logic [XLEN-1:0] f_pc;
    logic            f_ready;
    logic            d_valid;
    logic [ILEN-1:0] d_instr;
    logic [XLEN-1:0] d_pc;
    logic [2:0]      d_itype;
    logic            d_ready;

    modport slave (
        input  f_valid, f_instr, f_pc, d_ready,
        output f_ready, d_valid, d_instr, d_pc, d_itype
    );

    modport master (
        output f_valid, f_instr, f_pc, d_ready,
        input  f_ready, d_valid, d_instr, d_pc, d_itype
    );
endinterface

// File: rtl/decode_ctrl.sv
// Instruction buffer between fetch and decode: classifies each beat on entry,
// and halts on an illegal instruction until the pipeline is flushed.
module decode_ctrl #(
    parameter int unsigned ILEN  = 32,
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    decode_ctrl_if.slave             bus,
    input  logic                     flush,
    output logic                     trapped,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    localparam logic [2:0] ItR   = 3'd0;
    localparam logic [2:0] ItI   = 3'd1;
    localparam logic [2:0] ItS   = 3'd2;
    localparam logic [2:0] ItB   = 3'd3;
    localparam logic [2:0] ItU   = 3'd4;
    localparam logic [2:0] ItJ   = 3'd5;
    localparam logic [2:0] ItIll = 3'd7;

    typedef enum logic [0:0] {StRun, StTrap} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ill_pend_q, ill_pend_d;

    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [2:0]      itype_mem [DEPTH];

    logic            push;
    logic            pop;
    logic [2:0]      new_itype;

    function automatic logic [2:0] classify(input logic [6:0] op);
        logic [2:0] t;
        t = ItIll;
        if (op[1:0] == 2'b11) begin
            case (op)
                7'b0110011:                                     t = ItR;
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: t = ItI;
                7'b0100011:                                     t = ItS;
                7'b1100011:                                     t = ItB;
                7'b0110111, 7'b0010111:                         t = ItU;
                7'b1101111:                                     t = ItJ;
                default:                                        t = ItIll;
            endcase
        end
        return t;
    endfunction

    assign new_itype   = classify(bus.f_instr[6:0]);
    assign bus.d_instr = instr_mem[rd_ptr_q];
    assign bus.d_pc    = pc_mem[rd_ptr_q];
    assign bus.d_itype = itype_mem[rd_ptr_q];
    assign occupancy   = count_q;

    always_comb begin
        state_d     = state_q;
        ill_pend_d  = ill_pend_q;
        bus.d_valid = 1'b0;
        bus.f_ready = 1'b0;
        trapped     = 1'b0;

        unique case (state_q)
            StRun: begin
                bus.d_valid = (count_q != '0);
                // A pop frees a slot this cycle, so a full buffer can still accept.
                bus.f_ready = !ill_pend_q && !flush &&
                              ((count_q < DepthC) || (bus.d_valid && bus.d_ready));
                if (bus.d_valid && bus.d_ready && bus.d_itype == ItIll) begin
                    state_d = StTrap;
                end
            end
            StTrap: begin
                trapped = 1'b1;
            end
        endcase

        push = bus.f_valid && bus.f_ready;
        pop  = bus.d_valid && bus.d_ready;

        if (push && new_itype == ItIll) begin
            ill_pend_d = 1'b1;
        end

        count_d  = count_q + CW'(push) - CW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);

        if (flush) begin
            state_d    = StRun;
            ill_pend_d = 1'b0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            ill_pend_q <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            ill_pend_q <= ill_pend_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage is not reset; occupancy alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.f_instr;
            pc_mem[wr_ptr_q]    <= bus.f_pc;
            itype_mem[wr_ptr_q] <= new_itype;
        end
    end
endmodule

// File: tb/tb_decode_ctrl.sv
// Directed vector bench for decode_ctrl (DEPTH=2): each record gives the inputs for one
// cycle and the outputs expected in that cycle before the clock edge.
module tb_decode_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       trapped;
    logic [1:0] occupancy;

    int n_vec  = 0;
    int n_miss = 0;

    decode_ctrl_if #(.ILEN(32), .XLEN(32)) bus ();

    decode_ctrl #(.ILEN(32), .XLEN(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush     (flush),
        .trapped   (trapped),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        dr;
        logic        fl;
        logic        rs;
        logic        dv;
        logic [2:0]  it;
        logic [31:0] epc;
        logic [1:0]  occ;
        logic        fr;
        logic        tr;
    } vec_t;

    localparam int NV = 35;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic fv, input logic [31:0] instr, input logic [31:0] pc,
                                input logic dr, input logic fl, input logic rs, input logic dv,
                                input logic [2:0] it, input logic [31:0] epc,
                                input logic [1:0] occ, input logic fr, input logic tr);
        vec_t v;
        v.fv = fv; v.instr = instr; v.pc = pc; v.dr = dr; v.fl = fl; v.rs = rs;
        v.dv = dv; v.it = it; v.epc = epc; v.occ = occ; v.fr = fr; v.tr = tr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s @%0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //                fv  instr          pc            dr  fl  rs  dv  it  epc           occ fr  tr
        vecs[0]  = mk(1, 32'h00500093, 32'h0000_0000, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[1]  = mk(0, 32'h0,        32'h0,         0, 0, 0, 1, 1, 32'h0,        1, 1, 0);
        vecs[2]  = mk(1, 32'h00000013, 32'h0000_0004, 0, 0, 0, 1, 1, 32'h0,        1, 1, 0);
        vecs[3]  = mk(1, 32'h00000033, 32'h0000_0008, 0, 0, 0, 1, 1, 32'h0,        2, 0, 0);
        vecs[4]  = mk(1, 32'h00000033, 32'h0000_0008, 1, 0, 0, 1, 1, 32'h0,        2, 1, 0);
        vecs[5]  = mk(0, 32'h0,        32'h0,         0, 0, 0, 1, 1, 32'h4,        2, 0, 0);
        vecs[6]  = mk(0, 32'h0,        32'h0,         1, 0, 0, 1, 1, 32'h4,        2, 1, 0);
        vecs[7]  = mk(0, 32'h0,        32'h0,         1, 0, 0, 1, 0, 32'h8,        1, 1, 0);
        vecs[8]  = mk(0, 32'h0,        32'h0,         1, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[9]  = mk(1, 32'h00000063, 32'h0000_0100, 1, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[10] = mk(1, 32'h0000006F, 32'h0000_0104, 1, 0, 0, 1, 3, 32'h100,      1, 1, 0);
        vecs[11] = mk(1, 32'h00000037, 32'h0000_0108, 1, 0, 0, 1, 5, 32'h104,      1, 1, 0);
        vecs[12] = mk(1, 32'h00000023, 32'h0000_010C, 1, 0, 0, 1, 4, 32'h108,      1, 1, 0);
        vecs[13] = mk(1, 32'h00000033, 32'h0000_0110, 1, 0, 0, 1, 2, 32'h10C,      1, 1, 0);
        vecs[14] = mk(0, 32'h0,        32'h0,         1, 0, 0, 1, 0, 32'h110,      1, 1, 0);
        vecs[15] = mk(0, 32'h0,        32'h0,         1, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[16] = mk(1, 32'h0000007F, 32'h0000_0200, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[17] = mk(1, 32'h00000013, 32'h0000_0204, 0, 0, 0, 1, 7, 32'h200,      1, 0, 0);
        vecs[18] = mk(1, 32'h00000013, 32'h0000_0204, 1, 0, 0, 1, 7, 32'h200,      1, 0, 0);
        for (int i = 19; i < 24; i++)
            vecs[i] = mk(1, 32'h00000013, 32'h0000_0204, 1, 0, 0, 0, 0, 32'h0,    0, 0, 1);
        vecs[24] = mk(1, 32'h00000013, 32'h0000_0204, 1, 1, 0, 0, 0, 32'h0,        0, 0, 1);
        vecs[25] = mk(0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[26] = mk(1, 32'h00000013, 32'h0000_0300, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[27] = mk(1, 32'h00000033, 32'h0000_0304, 0, 0, 0, 1, 1, 32'h300,      1, 1, 0);
        vecs[28] = mk(1, 32'h00000063, 32'h0000_0308, 0, 1, 0, 1, 1, 32'h300,      2, 0, 0);
        vecs[29] = mk(0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[30] = mk(0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[31] = mk(1, 32'h00000013, 32'h0000_0400, 0, 0, 0, 0, 0, 32'h0,        0, 1, 0);
        vecs[32] = mk(1, 32'h00000033, 32'h0000_0404, 0, 0, 0, 1, 1, 32'h400,      1, 1, 0);
        vecs[33] = mk(1, 32'h00000063, 32'h0000_0408, 0, 0, 1, 1, 1, 32'h400,      2, 0, 0);
        vecs[34] = mk(0, 32'h0,        32'h0,         0, 0, 0, 0, 0, 32'h0,        0, 1, 0);

        rst = 1'b1; flush = 1'b0;
        bus.f_valid = 1'b0; bus.f_instr = '0; bus.f_pc = '0; bus.d_ready = 1'b0;
        tick();
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            bus.f_valid = vecs[i].fv;
            bus.f_instr = vecs[i].instr;
            bus.f_pc    = vecs[i].pc;
            bus.d_ready = vecs[i].dr;
            flush       = vecs[i].fl;
            rst         = vecs[i].rs;
            #1;
            chk("d_valid",   i, 32'(bus.d_valid), 32'(vecs[i].dv));
            chk("occupancy", i, 32'(occupancy),   32'(vecs[i].occ));
            chk("f_ready",   i, 32'(bus.f_ready), 32'(vecs[i].fr));
            chk("trapped",   i, 32'(trapped),     32'(vecs[i].tr));
            if (vecs[i].dv) begin
                chk("d_itype", i, 32'(bus.d_itype), 32'(vecs[i].it));
                chk("d_pc",    i, bus.d_pc,         vecs[i].epc);
            end
            tick();
        end

        // Low bits != 2'b11 is illegal; flush on the same cycle the illegal head pops
        // must leave the controller running, not trapped.
        rst = 1'b0; flush = 1'b0;
        bus.f_valid = 1'b1; bus.f_instr = 32'h00000031; bus.f_pc = 32'h500; bus.d_ready = 1'b0;
        tick();
        bus.f_valid = 1'b1; bus.f_instr = 32'h00000013; bus.f_pc = 32'h504;
        #1;
        chk("seq_ill_itype",  100, 32'(bus.d_itype), 32'd7);
        chk("seq_ill_pc",     100, bus.d_pc,         32'h500);
        chk("seq_ill_fready", 100, 32'(bus.f_ready), 32'd0);
        bus.d_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; bus.f_valid = 1'b0; bus.d_ready = 1'b0;
        #1;
        chk("seq_fl_trapped", 101, 32'(trapped),     32'd0);
        chk("seq_fl_occ",     101, 32'(occupancy),   32'd0);
        chk("seq_fl_fready",  101, 32'(bus.f_ready), 32'd1);

        // Stall holds the head stable across several cycles.
        bus.f_valid = 1'b1; bus.f_instr = 32'h0000006F; bus.f_pc = 32'h600;
        tick();
        bus.f_valid = 1'b1; bus.f_instr = 32'h00000023; bus.f_pc = 32'h604;
        tick();
        bus.f_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_instr", 200 + k, bus.d_instr,        32'h0000006F);
            chk("hold_itype", 200 + k, 32'(bus.d_itype),   32'd5);
            chk("hold_occ",   200 + k, 32'(occupancy),     32'd2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
